// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter: FSM state, default widths,
// and the wrapping priority search used by the grant encoder.
package ram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ID_WIDTH   = 4;
    localparam int MAX_REQ        = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping modulo num (ptr < num).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int unsigned ptr,
                                      input int unsigned num);
        pick_t       res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            cand = ptr + k;
            if (cand >= num) cand = cand - num;
            if (k < num && !res.found && valid[cand[3:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Wrapping priority encoder: grants the first requester at or after ptr.
// Tie ptr to zero for plain lowest-index-wins priority.
module rr_priority_encoder
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] grant,
    output logic                grant_valid
);

    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_ext, 32'(ptr), 32'(NUM_REQ));
        grant                = ID_WIDTH'(pick.idx);
        grant_valid          = pick.found;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous single-port RAM among NUM_REQ requesters, one grant per
// cycle, read data returned two cycles after accept. Define ARB_FIXED_PRIO_EN for fixed priority.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    input  logic [DATA_WIDTH-1:0]          ram_rdata,
    output logic                           busy
);

    // Handshake: a request transfers when req_valid[i] & req_ready[i]; ready is
    // combinational, at most one bit set, and requesters hold fields until then.

    arb_state_t          state;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] grant;
    logic                grant_valid;
    logic                grant_en;
    logic [ID_WIDTH-1:0] rsp_id;
    logic                rsp_pend;
    logic [ADDR_WIDTH-1:0] addr_q;

`ifdef ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [ID_WIDTH-1:0] rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign ptr = rr_ptr;
`endif

    rr_priority_encoder #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_enc (
        .req        (req_valid),
        .ptr        (ptr),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    assign grant_en = grant_valid & ~rst;

    // Idle cycles keep the last address on the RAM so its read register is undisturbed.
    always_comb begin
        req_ready = '0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_en && grant == ID_WIDTH'(i)) begin
                req_ready[i] = 1'b1;
                ram_we       = req_we[i];
                ram_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wdata    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            addr_q    <= '0;
            rsp_pend  <= 1'b0;
            rsp_id    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!(|req_valid) && !rsp_pend) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (grant_en) begin
                addr_q   <= ram_addr;
                rsp_pend <= ~ram_we;
                rsp_id   <= grant;
            end else begin
                rsp_pend <= 1'b0;
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] <= rsp_pend && (rsp_id == ID_WIDTH'(i));
            end
            if (rsp_pend) begin
                rsp_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-address RAM
// and a queue scoreboard checking response id, data and arrival cycle.
module tb_ram_port_arbiter;

    localparam int N  = 16;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       req_we;
    logic [N*AW-1:0]    req_addr;
    logic [N*DW-1:0]    req_wdata;
    logic [N-1:0]       rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic [DW-1:0]      ram_rdata;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [N+DW-1:0] exp_q[$];
    int              exp_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // Synchronous single-port RAM with registered read address.
    logic [DW-1:0] mem [0:1023];
    logic [AW-1:0] ram_addr_r = '0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
        ram_addr_r <= ram_addr;
    end
    assign ram_rdata = mem[ram_addr_r[9:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]            = 1'b1;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string name, input logic [N-1:0] exp);
        @(negedge clk);
        chk(name, 64'(req_ready), 64'(exp));
    endtask

    // Called during the accept cycle; response is due two cycles later.
    task automatic push_rsp(input int id, input logic [DW-1:0] data);
        logic [N-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        exp_q.push_back({oh, data});
        exp_cyc_q.push_back(cyc + 2);
    endtask

    // Monitor: every response strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=%0h rdata=%0h expected none", rsp_valid, rsp_rdata);
            end else begin
                logic [N+DW-1:0] e;
                int              c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(e[N+DW-1:DW]));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
                chk("rsp_cycle", 64'(cyc), 64'(c));
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[10'h100 + i] = 32'hA000_0000 + i;
        rst = 1'b1;
        clr();
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'h0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_ram_we",    64'(ram_we),    64'h0);
        chk("reset_ram_addr",  64'(ram_addr),  64'h0);
        chk("reset_ram_wdata", 64'(ram_wdata), 64'h0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("reset_busy",      64'(busy),      64'h0);
        repeat (2) next();
        rst = 1'b0;
        next();

        // Single write then read-back by requester 0.
        set_req(0, 1'b1, 16'h0005, 32'hDEAD_BEEF);
        expect_grant("wr0_grant", 16'h0001);
        chk("wr0_ram_we",    64'(ram_we),    64'h1);
        chk("wr0_ram_addr",  64'(ram_addr),  64'h5);
        chk("wr0_ram_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
        next();
        clr();
        set_req(0, 1'b0, 16'h0005, 32'h0);
        expect_grant("rd0_grant", 16'h0001);
        chk("rd0_ram_we", 64'(ram_we), 64'h0);
        chk("busy_active", 64'(busy), 64'h1);
        push_rsp(0, 32'hDEAD_BEEF);
        next();
        clr();
        repeat (3) next();
        @(negedge clk);
        chk("busy_drained",   64'(busy),     64'h0);
        chk("idle_addr_hold", 64'(ram_addr), 64'h5);
        chk("idle_ram_we",    64'(ram_we),   64'h0);
        next();

        // Write by req3 immediately followed by read of the same address by req7.
        set_req(3, 1'b1, 16'h0010, 32'h0000_1234);
        expect_grant("col_wr3", 16'h0008);
        next();
        clr();
        set_req(7, 1'b0, 16'h0010, 32'h0);
        expect_grant("col_rd7", 16'h0080);
        push_rsp(7, 32'h0000_1234);
        next();
        clr();
        repeat (3) next();

        // Reset asserted while a read response is pending: it must be dropped.
        set_req(2, 1'b0, 16'h0105, 32'h0);
        expect_grant("mid_rd2", 16'h0004);
        next();
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("midrst_ram_we",    64'(ram_we),    64'h0);
        chk("midrst_req_ready", 64'(req_ready), 64'h0);
        chk("midrst_busy",      64'(busy),      64'h0);
        clr();
        repeat (2) next();
        chk("midrst_rsp_later", 64'(rsp_valid), 64'h0);
        rst = 1'b0;
        next();

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: req0 starves req5 until it drops.
        set_req(0, 1'b0, 16'h0100, 32'h0);
        set_req(5, 1'b0, 16'h0105, 32'h0);
        for (int k = 0; k < 3; k++) begin
            expect_grant("fix_req0", 16'h0001);
            push_rsp(0, 32'hA000_0000);
            next();
        end
        req_valid[0] = 1'b0;
        expect_grant("fix_req5", 16'h0020);
        push_rsp(5, 32'hA000_0005);
        next();
        clr();
        repeat (3) next();
`else
        // All 16 requesters reading: pointer starts at 0 after reset.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h0100 + 16'(i), 32'h0);
        for (int k = 0; k <= N; k++) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[k % N] = 1'b1;
            expect_grant("rr_all", oh);
            push_rsp(k % N, 32'hA000_0000 + (k % N));
            next();
        end
        clr();
        repeat (3) next();

        // Wrap-around: move pointer to 15, then req15/req0 alternate.
        set_req(14, 1'b0, 16'h010E, 32'h0);
        expect_grant("wrap_req14", 16'h4000);
        push_rsp(14, 32'hA000_000E);
        next();
        clr();
        set_req(15, 1'b0, 16'h010F, 32'h0);
        set_req(0,  1'b0, 16'h0100, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k % 2 == 0) begin
                expect_grant("wrap_req15", 16'h8000);
                push_rsp(15, 32'hA000_000F);
            end else begin
                expect_grant("wrap_req0", 16'h0001);
                push_rsp(0, 32'hA000_0000);
            end
            next();
        end
        clr();
        repeat (3) next();
`endif

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) next();
        if (exp_q.size() != 0) begin
            $display("FAIL rsp_timeout: got %0d outstanding expected 0", exp_q.size());
            total++;
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
